// File: rtl/keypad_time_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mw_pkg
// Brief    : Shared types and constants for the keypad time-entry front end
//            of the countdown timer chain.
// Revision : 1.0 - initial release
// ============================================================================
package mw_pkg;

  // Width of one BCD digit and of the full MM:SS buffer
  localparam int BCD_W = 4;
  localparam int BUF_W = 4 * BCD_W;

  // Largest keypad code that counts as a digit
  localparam logic [BCD_W-1:0] KEY_MAX_DIGIT = 4'd9;

  // Number of digits the buffer can hold
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  // Default one-touch cook time (30 s)
  localparam logic [BUF_W-1:0] QUICK_TIME_DEFAULT = 16'h0030;

  // Controller state encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  // True when a keypad code is a decimal digit
  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return (code <= KEY_MAX_DIGIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_time_entry_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_time_entry_if
// Brief    : Keypad / control inputs and counter-chain control outputs of the
//            time-entry block, bundled with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_time_entry_if;
  import mw_pkg::*;

  logic             key_valid;
  logic [BCD_W-1:0] key_code;
  logic             start;
  logic             stop;
  logic             chain_tc;
  logic [BUF_W-1:0] data;
  logic             loadn;
  logic             cnt_en;
  logic             cnt_clrn;
  logic             running;
  logic             done;
  logic             err;

  // Driver of keypad/control inputs, observer of the counter controls
  modport master (
    output key_valid, key_code, start, stop, chain_tc,
    input  data, loadn, cnt_en, cnt_clrn, running, done, err
  );

  // The time-entry controller itself
  modport slave (
    input  key_valid, key_code, start, stop, chain_tc,
    output data, loadn, cnt_en, cnt_clrn, running, done, err
  );

endinterface
`default_nettype wire

// File: rtl/keypad_time_entry_key_edge_filter.sv
`default_nettype none
// ============================================================================
// Module   : key_edge_filter
// Brief    : Turns the keypad "key held" level into a one-cycle strobe on its
//            rising edge, qualified so only digit codes 0-9 get through.
// Revision : 1.0 - initial release
// ============================================================================
module key_edge_filter
  import mw_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             clrn,
  input  wire logic             i_key_valid,
  input  wire logic [BCD_W-1:0] i_key_code,
  output logic                  o_digit_strobe,
  output logic [BCD_W-1:0]      o_digit_code
);

  logic r_key_prev;
  logic w_rise;

  // Remember last cycle's key level so a held key fires only once
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key_prev <= 1'b0;
    end else begin
      r_key_prev <= i_key_valid;
    end
  end

  assign w_rise         = i_key_valid & ~r_key_prev;
  assign o_digit_strobe = w_rise & is_digit(i_key_code);
  assign o_digit_code   = i_key_code;

endmodule
`default_nettype wire

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_time_entry
// Brief    : Collects keypad digits into an MM:SS BCD buffer (shift-in from the
//            right) and sequences the BCD down-counter chain through entry,
//            load, run, pause and finish.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_time_entry
  import mw_pkg::*;
#(
  parameter logic [BUF_W-1:0] QUICK_TIME   = QUICK_TIME_DEFAULT,
  parameter logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5
)(
  input wire logic           clk,
  input wire logic           clrn,
  keypad_time_entry_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [BUF_W-1:0] r_buf;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;

  logic             w_dig;
  logic [BCD_W-1:0] w_code;
  logic             w_reject;
  logic             w_err;
  logic             w_done;
  logic             w_clr;

  logic             r_loadn;
  logic             r_run;
  logic             r_cnt_clrn;
  logic             r_done;
  logic             r_err;

  key_edge_filter u_key_edge_filter (
    .clk            (clk),
    .clrn           (clrn),
    .i_key_valid    (bus.key_valid),
    .i_key_code     (bus.key_code),
    .o_digit_strobe (w_dig),
    .o_digit_code   (w_code)
  );

  // A start is refused for an empty time or an impossible seconds-tens digit
  assign w_reject = (r_buf[7:4] > MAX_SEC_TENS) || (r_buf == '0);

  // Next-state, buffer update and one-cycle pulse decisions
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop does nothing here; start beats a simultaneous key
        if (!bus.stop) begin
          if (bus.start) begin
            w_buf_nxt   = QUICK_TIME;
            w_state_nxt = S_LOAD;
          end else if (w_dig) begin
            w_buf_nxt   = {r_buf[BUF_W-BCD_W-1:0], w_code};
            w_cnt_nxt   = 3'd1;
            w_state_nxt = S_ENTRY;
          end
        end
      end
      S_ENTRY: begin
        if (bus.stop) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end else if (bus.start) begin
          if (w_reject) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else if (w_dig && (r_cnt < MAX_DIGITS)) begin
          w_buf_nxt = {r_buf[BUF_W-BCD_W-1:0], w_code};
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Reaching zero outranks a late stop
        if (bus.chain_tc) begin
          w_done      = 1'b1;
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end else if (bus.stop) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_clr       = 1'b1;
          w_buf_nxt   = '0;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end else if (bus.start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_buf_nxt   = '0;
        w_cnt_nxt   = 3'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, buffer and digit-count registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Control outputs registered from the decision so they line up with the state
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_loadn    <= 1'b1;
      r_run      <= 1'b0;
      r_cnt_clrn <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_loadn    <= (w_state_nxt != S_LOAD);
      r_run      <= (w_state_nxt == S_RUN);
      r_cnt_clrn <= ~w_clr;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign bus.data     = r_buf;
  assign bus.loadn    = r_loadn;
  assign bus.cnt_en   = r_run;
  assign bus.running  = r_run;
  assign bus.cnt_clrn = r_cnt_clrn;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_time_entry
// Brief    : Self-checking bench for keypad_time_entry: directed vector table,
//            hand sequences for multi-cycle corners, and random stimulus
//            against a digit-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_time_entry;

  // Control vector order: {loadn, cnt_en, cnt_clrn, running, done, err}
  localparam logic [5:0] C_IDLE = 6'b101000;
  localparam logic [5:0] C_LOAD = 6'b001000;
  localparam logic [5:0] C_RUN  = 6'b111100;
  localparam logic [5:0] C_DONE = 6'b101010;
  localparam logic [5:0] C_ERR  = 6'b101001;
  localparam logic [5:0] C_CLR  = 6'b100000;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;
  localparam int M_PAUSE = 4;

  typedef struct packed {
    logic        kv;
    logic [3:0]  code;
    logic        st;
    logic        sp;
    logic        tc;
    logic [15:0] edata;
    logic [5:0]  ectl;
  } vec_t;

  logic clk;
  logic clrn;
  int   n_chk;
  int   n_pass;

  keypad_time_entry_if kif ();

  keypad_time_entry dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: mode plus the list of entered digits
  int m_mode;
  int m_q[$];
  bit m_kprev;

  function automatic logic [5:0] ctl();
    return {kif.loadn, kif.cnt_en, kif.cnt_clrn, kif.running, kif.done, kif.err};
  endfunction

  function automatic logic [15:0] fold();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic drive(input logic kv, input logic [3:0] code, input logic st,
                       input logic sp, input logic tc);
    kif.key_valid = kv;
    kif.key_code  = code;
    kif.start     = st;
    kif.stop      = sp;
    kif.chain_tc  = tc;
  endtask

  task automatic cyc(input logic kv, input logic [3:0] code, input logic st,
                     input logic sp, input logic tc);
    drive(kv, code, st, sp, tc);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One model step from the inputs seen at the clock edge; returns expected controls
  task automatic model_step(input logic kv, input logic [3:0] code, input logic st,
                            input logic sp, input logic tc, output logic [5:0] ectl);
    bit e_done = 0;
    bit e_err  = 0;
    bit e_clr  = 0;
    bit dig    = kv && !m_kprev && (code <= 4'd9);
    int stens;
    m_kprev = kv;
    case (m_mode)
      M_IDLE: begin
        if (!sp) begin
          if (st) begin
            m_q = '{0, 0, 3, 0};
            m_mode = M_LOAD;
          end else if (dig) begin
            m_q = '{int'(code)};
            m_mode = M_ENTRY;
          end
        end
      end
      M_ENTRY: begin
        if (sp) begin
          m_q = {};
          m_mode = M_IDLE;
        end else if (st) begin
          stens = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 0;
          if (fold() == 16'h0 || stens > 5) e_err = 1;
          else m_mode = M_LOAD;
        end else if (dig && m_q.size() < 4) begin
          m_q.push_back(int'(code));
        end
      end
      M_LOAD: m_mode = M_RUN;
      M_RUN: begin
        if (tc) begin
          e_done = 1;
          m_q = {};
          m_mode = M_IDLE;
        end else if (sp) begin
          m_mode = M_PAUSE;
        end
      end
      default: begin
        if (sp) begin
          e_clr = 1;
          m_q = {};
          m_mode = M_IDLE;
        end else if (st) begin
          m_mode = M_RUN;
        end
      end
    endcase
    ectl = {m_mode != M_LOAD, m_mode == M_RUN, !e_clr, m_mode == M_RUN, e_done, e_err};
  endtask

  vec_t tab[28];

  initial begin
    n_chk  = 0;
    n_pass = 0;

    tab[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0001, C_IDLE};
    tab[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0001, C_IDLE};
    tab[2]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0012, C_IDLE};
    tab[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0012, C_IDLE};
    tab[4]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0123, C_IDLE};
    tab[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0123, C_IDLE};
    tab[6]  = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1230, C_IDLE};
    tab[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1230, C_IDLE};
    tab[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h1230, C_LOAD};
    tab[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1230, C_RUN};
    tab[10] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h1230, C_IDLE};
    tab[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h1230, C_RUN};
    tab[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, C_DONE};
    tab[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, C_IDLE};
    tab[14] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0001, C_IDLE};
    tab[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0001, C_IDLE};
    tab[16] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 16'h0017, C_IDLE};
    tab[17] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0017, C_IDLE};
    tab[18] = '{1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0175, C_IDLE};
    tab[19] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0175, C_IDLE};
    tab[20] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0175, C_ERR};
    tab[21] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0175, C_IDLE};
    tab[22] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, C_IDLE};
    tab[23] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0030, C_LOAD};
    tab[24] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0030, C_RUN};
    tab[25] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0030, C_IDLE};
    tab[26] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, C_CLR};
    tab[27] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, C_IDLE};

    // Reset
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_data", 32'(kif.data), 32'h0);
    chk("reset_ctl", 32'(ctl()), 32'(C_IDLE));
    clrn = 1'b1;

    // Directed table
    foreach (tab[i]) begin
      cyc(tab[i].kv, tab[i].code, tab[i].st, tab[i].sp, tab[i].tc);
      chk($sformatf("tab%0d_data", i), 32'(kif.data), 32'(tab[i].edata));
      chk($sformatf("tab%0d_ctl", i), 32'(ctl()), 32'(tab[i].ectl));
    end

    // Six digits: only the first four land
    for (int d = 1; d <= 6; d++) begin
      cyc(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      if (d == 4) chk("six_dig_4th", 32'(kif.data), 32'h1234);
    end
    chk("six_dig_sat", 32'(kif.data), 32'h1234);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("six_dig_clear", 32'(kif.data), 32'h0);

    // Held key accepted once; non-digit code ignored
    for (int k = 0; k < 10; k++) cyc(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("hold_key", 32'(kif.data), 32'h0008);
    cyc(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("nondigit", 32'(kif.data), 32'h0008);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // start and stop together in ENTRY: stop wins
    cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("ss_entry", 32'(kif.data), 32'h0004);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("ss_data", 32'(kif.data), 32'h0);
    chk("ss_ctl", 32'(ctl()), 32'(C_IDLE));
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("ss_idle_quick", 32'(kif.data), 32'h0030);
    chk("ss_idle_load", 32'(ctl()), 32'(C_LOAD));

    // Asynchronous reset in the middle of RUN
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_run", 32'(ctl()), 32'(C_RUN));
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("async_rst_data", 32'(kif.data), 32'h0);
    @(negedge clk);
    clrn = 1'b1;

    // Random stimulus against the reference model
    m_mode  = M_IDLE;
    m_q     = {};
    m_kprev = 0;
    begin
      logic       kv = 1'b0;
      logic [3:0] code = 4'd0;
      logic       st, sp, tc;
      logic [5:0] ectl;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 2) == 0) begin
          if (!kv) code = 4'($urandom_range(0, 15));
          kv = ~kv;
        end
        st = ($urandom_range(0, 7) == 0);
        sp = ($urandom_range(0, 15) == 0);
        tc = ($urandom_range(0, 9) == 0);
        model_step(kv, code, st, sp, tc, ectl);
        cyc(kv, code, st, sp, tc);
        chk($sformatf("rnd%0d_data", n), 32'(kif.data), 32'(fold()));
        chk($sformatf("rnd%0d_ctl", n), 32'(ctl()), 32'(ectl));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Upstream stage of the countdown timer chain. It collects keypad digits into a 4-digit BCD buffer (MM:SS, microwave-style shift-in from the right).
- It drives the parallel-load, enable and clear controls of the cascaded mod-10/mod-6 BCD counters.
- It sequences cooking as entry, load, run, pause and finish, using the counter chain's terminal-count flag.

Parameters:
- QUICK_TIME, 16'h0030, BCD value loaded when start is pressed with an empty buffer (30 s).
- MAX_SEC_TENS, 4'd5, largest legal seconds-tens digit.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- key_valid  in  1  keypad encoder "key held" level, synchronous to clk
- key_code  in  4  keypad code; 0-9 are digits, 10-15 are ignored
- start  in  1  single-cycle start/resume pulse
- stop  in  1  single-cycle stop/cancel pulse
- chain_tc  in  1  high when the whole counter chain reads 00:00 while counting
- data  out  16  {min_t, min_u, sec_t, sec_u} BCD load value to counters
- loadn  out  1  active-low parallel load to counters
- cnt_en  out  1  count-down enable to counters
- cnt_clrn  out  1  active-low synchronous clear to counters
- running  out  1  high in RUN (magnetron/turntable enable)
- done  out  1  single-cycle pulse at cook completion
- err  out  1  single-cycle pulse on rejected start

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE, buffer=16'h0000, digit count=0, key_prev=0.
  - data=0, loadn=1, cnt_en=0, cnt_clrn=1, running=0, done=0, err=0.
- Key detection:
  - A key is accepted on the rising edge of key_valid (key_valid=1 and registered key_prev=0). It takes effect in the same cycle.
  - Holding the key does not repeat. Codes above 9 are discarded.
- States: IDLE, ENTRY, LOAD, RUN, PAUSE.
- IDLE:
  - An accepted digit shifts in: buffer={buffer[11:0],key}, count=1, go to ENTRY.
  - start: buffer=QUICK_TIME, go to LOAD.
  - stop: no effect.
- ENTRY:
  - Each accepted digit shifts left while count<4. A 5th and later digit is ignored; the buffer is unchanged and count saturates at 4.
  - start with buffer[7:4]>MAX_SEC_TENS, or with buffer==0: err=1 for one cycle, stay in ENTRY, buffer unchanged.
  - Any other start: go to LOAD.
  - stop: buffer=0, count=0, go to IDLE.
- LOAD:
  - Exactly one cycle with loadn=0, cnt_en=0, data=buffer.
  - Unconditionally go to RUN next cycle; start, stop and keys are ignored in LOAD.
- RUN:
  - cnt_en=1, running=1.
  - chain_tc=1: done=1 for one cycle, buffer=0, count=0, go to IDLE.
  - stop: go to PAUSE.
  - Keys and start are ignored.
- PAUSE:
  - cnt_en=0, running=0; counter contents are held.
  - start: go to RUN, with no reload.
  - stop: cnt_clrn=0 for one cycle, buffer=0, count=0, go to IDLE.
- Priority within a cycle:
  - In RUN: chain_tc > stop.
  - Elsewhere: stop > start > key.
  - A key edge in the same cycle as start is dropped.
- Output registering: data always equals buffer. All control outputs are registered, with one cycle latency from the decision edge.
- Reset mid-RUN: all outputs return to reset values immediately. Counters are cleared by their own clrn.

Decomposition:
- Shared package mw_pkg:
  - state encoding localparams (S_IDLE..S_PAUSE, 3 bits)
  - KEY_MAX_DIGIT=9
  - BCD digit width 4
  - default QUICK_TIME
- One natural sub-module, key_edge_filter: registered key_prev, a rising-edge strobe, and a code<=9 qualifier producing digit_strobe/digit_code.

Test Plan:
- Reset, then key pulses 1,2,3,0 (one key per 3 cycles), then start:
  - buffer=16'h1230.
  - A single-cycle loadn=0 with data=16'h1230, then cnt_en=1 and running=1.
- Six digits 1..6 entered in ENTRY:
  - Buffer stops at 16'h1234 after the 4th digit; the 5th and 6th digits are ignored.
- Entry 1,7,5 (buffer 16'h0175, sec_t=7), then start:
  - err pulses once, state stays ENTRY, loadn stays 1.
- start in IDLE with an empty buffer:
  - loadn pulse with data=16'h0030; RUN follows.
- RUN, then stop, then start:
  - PAUSE: cnt_en=0 with no loadn.
  - Resume to RUN: cnt_en=1.
  - chain_tc=1: done pulse, cnt_en=0, buffer=0, IDLE.
- Hold key_valid=1 with code 8 for 10 cycles:
  - Exactly one digit accepted.
- Assert clrn=0 mid-RUN:
  - Outputs return to reset values asynchronously.
- start and stop in the same ENTRY cycle:
  - stop wins; buffer=0, IDLE.
